// File: rtl/sim_supervisor_if.sv
// OCP-style register bus between a simulation master and the sim_supervisor slave.
interface sim_supervisor_if;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BEN_WIDTH  = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] i_MAddr;
  logic [2:0]            i_MCmd;
  logic [DATA_WIDTH-1:0] i_MData;
  logic [BEN_WIDTH-1:0]  i_MByteEn;
  logic                  o_SCmdAccept;
  logic [DATA_WIDTH-1:0] o_SData;
  logic [1:0]            o_SResp;

  modport master (
    output i_MAddr, i_MCmd, i_MData, i_MByteEn,
    input  o_SCmdAccept, o_SData, o_SResp
  );

  modport slave (
    input  i_MAddr, i_MCmd, i_MData, i_MByteEn,
    output o_SCmdAccept, o_SData, o_SResp
  );
endinterface

// File: rtl/sim_supervisor.sv
// Simulation supervisor: OCP register slave with finish/error control, a 64-bit
// cycle counter, a watchdog, scratch registers and a character console.
module sim_supervisor #(
  parameter int unsigned NSCRATCH     = 4,
  parameter int unsigned FINISH_DELAY = 16,
  parameter int unsigned WDOG_RESET   = 0
) (
  input  logic            clk,
  input  logic            rst,
  sim_supervisor_if.slave ocp,
  output logic            o_finish,
  output logic            o_error,
  output logic            o_con_valid,
  output logic [7:0]      o_con_data
);
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = DW / 8;
  localparam int unsigned NSLOT = 8;
  localparam int unsigned DCW   = (FINISH_DELAY > 1) ? $clog2(FINISH_DELAY) : 1;

  localparam logic [2:0] CMD_WRITE = 3'd1;
  localparam logic [2:0] CMD_READ  = 3'd2;
  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_DVA  = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd3;

  localparam logic [3:0] REG_CTRL    = 4'h0;
  localparam logic [3:0] REG_STATUS  = 4'h1;
  localparam logic [3:0] REG_CYC_LO  = 4'h2;
  localparam logic [3:0] REG_CYC_HI  = 4'h3;
  localparam logic [3:0] REG_WDOG    = 4'h4;
  localparam logic [3:0] REG_CONSOLE = 4'h5;

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_DONE = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [63:0]     cyc_q;
  logic [DW-1:0]   snap_q, ctrl_q, wdog_q, wdog_d;
  logic [DW-1:0]   scr_q [NSLOT];
  logic            finish_q, finish_d, error_q, error_d, expired_q, expired_d;
  logic [DCW-1:0]  drain_cnt_q, drain_cnt_d;
  logic [1:0]      resp_q;
  logic [DW-1:0]   sdata_q;
  logic            con_valid_q;
  logic [7:0]      con_data_q;

  logic            is_wr, is_rd, acc_ok, wr_ok, rd_ok;
  logic [3:0]      idx;
  logic [DW-1:0]   rdata;
  logic            ctrl_wr, wdog_wr, con_wr, scr_wr, cyc_lo_rd;
  logic            fin_req, err_req, wdog_expire;
  logic            unused_addr;

  function automatic logic [DW-1:0] merge_be(input logic [DW-1:0] old_v,
                                             input logic [DW-1:0] new_v,
                                             input logic [BW-1:0] be);
    logic [DW-1:0] res;
    res = old_v;
    for (int unsigned b = 0; b < BW; b++)
      if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
    return res;
  endfunction

  // Command decode; accept is combinational, no wait states
  assign idx              = ocp.i_MAddr[5:2];
  assign is_wr            = (ocp.i_MCmd == CMD_WRITE);
  assign is_rd            = (ocp.i_MCmd == CMD_READ);
  assign ocp.o_SCmdAccept = is_wr | is_rd;
  assign unused_addr      = ^{ocp.i_MAddr[31:6], ocp.i_MAddr[1:0]};

  // Register map: legality of the access and read mux
  always_comb begin
    acc_ok = 1'b0;
    rdata  = '0;
    case (idx)
      REG_CTRL:    begin acc_ok = 1'b1;  rdata = ctrl_q; end
      REG_STATUS:  begin acc_ok = is_rd; rdata = DW'({state_q, expired_q, error_q, finish_q}); end
      REG_CYC_LO:  begin acc_ok = is_rd; rdata = cyc_q[31:0]; end
      REG_CYC_HI:  begin acc_ok = is_rd; rdata = snap_q; end
      REG_WDOG:    begin acc_ok = 1'b1;  rdata = wdog_q; end
      REG_CONSOLE: acc_ok = is_wr;
      default: begin
        if (idx[3] && (32'(idx[2:0]) < NSCRATCH)) begin
          acc_ok = 1'b1;
          rdata  = scr_q[idx[2:0]];
        end
      end
    endcase
  end

  assign wr_ok       = is_wr & acc_ok;
  assign rd_ok       = is_rd & acc_ok;
  assign ctrl_wr     = wr_ok && (idx == REG_CTRL);
  assign wdog_wr     = wr_ok && (idx == REG_WDOG);
  assign con_wr      = wr_ok && (idx == REG_CONSOLE) && ocp.i_MByteEn[0];
  assign scr_wr      = wr_ok && idx[3];
  assign cyc_lo_rd   = rd_ok && (idx == REG_CYC_LO);
  assign fin_req     = ctrl_wr && ocp.i_MByteEn[0] && ocp.i_MData[0];
  assign err_req     = ctrl_wr && ocp.i_MByteEn[3] && ocp.i_MData[31];
  // A watchdog write in the expiring cycle reloads instead of expiring
  assign wdog_expire = (state_q == ST_RUN) && !wdog_wr && (wdog_q == DW'(1));

  always_comb begin
    wdog_d = wdog_q;
    if (wdog_wr)
      wdog_d = merge_be(wdog_q, ocp.i_MData, ocp.i_MByteEn);
    else if ((state_q == ST_RUN) && (wdog_q != '0))
      wdog_d = wdog_q - DW'(1);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (fin_req || wdog_expire) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_cnt_q == DCW'(FINISH_DELAY - 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  // FSM outputs: sticky termination flags and drain timer
  always_comb begin
    finish_d    = finish_q;
    error_d     = error_q;
    expired_d   = expired_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (err_req || wdog_expire) error_d = 1'b1;
        if (wdog_expire)            expired_d = 1'b1;
        if (state_d == ST_DRAIN) begin
          finish_d    = 1'b1;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: drain_cnt_d = drain_cnt_q + DCW'(1);
      default:  drain_cnt_d = drain_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q       <= '0;
      snap_q      <= '0;
      ctrl_q      <= '0;
      wdog_q      <= DW'(WDOG_RESET);
      finish_q    <= 1'b0;
      error_q     <= 1'b0;
      expired_q   <= 1'b0;
      drain_cnt_q <= '0;
      resp_q      <= RESP_NULL;
      sdata_q     <= '0;
      con_valid_q <= 1'b0;
      con_data_q  <= '0;
      for (int unsigned n = 0; n < NSLOT; n++) scr_q[n] <= '0;
    end else begin
      cyc_q       <= cyc_q + 64'd1;
      wdog_q      <= wdog_d;
      finish_q    <= finish_d;
      error_q     <= error_d;
      expired_q   <= expired_d;
      drain_cnt_q <= drain_cnt_d;
      if (cyc_lo_rd) snap_q <= cyc_q[63:32];
      if (ctrl_wr)   ctrl_q <= merge_be(ctrl_q, ocp.i_MData, ocp.i_MByteEn);
      for (int unsigned n = 0; n < NSLOT; n++)
        if (scr_wr && (idx[2:0] == 3'(n)))
          scr_q[n] <= merge_be(scr_q[n], ocp.i_MData, ocp.i_MByteEn);
      if (ocp.o_SCmdAccept) resp_q <= acc_ok ? RESP_DVA : RESP_ERR;
      else                  resp_q <= RESP_NULL;
      sdata_q     <= rd_ok ? rdata : '0;
      con_valid_q <= con_wr;
      if (con_wr) con_data_q <= ocp.i_MData[7:0];
    end
  end

  assign ocp.o_SResp = resp_q;
  assign ocp.o_SData = sdata_q;
  assign o_finish    = finish_q;
  assign o_error     = error_q;
  assign o_con_valid = con_valid_q;
  assign o_con_data  = con_data_q;

`ifndef SYNTHESIS
  // Simulation-only console echo and end-of-test handling
  always_ff @(posedge clk) begin
    if (!rst && con_wr) $write("%c", ocp.i_MData[7:0]);
    if (!rst && (state_q == ST_DRAIN) && (state_d == ST_DONE)) begin
      $display("\nsim_supervisor: simulation done, finish=%0d error=%0d expired=%0d cycle=%0d",
               finish_q, error_q, expired_q, cyc_q);
      $finish;
    end
  end
`endif
endmodule

// File: doc/sim_supervisor.md
SIM_SUPERVISOR -- requirements
Module: sim_supervisor

Interface
REQ-001 Parameters SHALL be, one per line:
 - NSCRATCH, 4, number of 32-bit scratch registers (1..8)
 - FINISH_DELAY, 16, cycles between finish request and simulation end (>=1)
 - WDOG_RESET, 0, watchdog reload value after reset (0 = disabled)
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, one per line:
 - clk  in  1  clock, all logic on rising edge
 - rst  in  1  synchronous active-high reset
 - i_MAddr  in  `ADDR_WIDTH  OCP byte address, decoded on bits [5:2]
 - i_MCmd  in  3  OCP command (IDLE/WRITE/READ)
 - i_MData  in  `DATA_WIDTH  OCP write data
 - i_MByteEn  in  `BEN_WIDTH  OCP byte enables
 - o_SCmdAccept  out  1  command accepted
 - o_SData  out  `DATA_WIDTH  read data
 - o_SResp  out  2  OCP response (NULL/DVA/ERR)
 - o_finish  out  1  finish requested (sticky)
 - o_error  out  1  termination is erroneous (sticky)
 - o_con_valid  out  1  console character strobe, one cycle
 - o_con_data  out  8  console character

Function
REQ-004 Register map (byte offset): 0x00 CTRL rw; 0x04 STATUS ro; 0x08 CYCLE_LO ro; 0x0C CYCLE_HI ro; 0x10 WDOG rw; 0x14 CONSOLE wo; 0x20+4n SCRATCH[n] rw, n<NSCRATCH.
REQ-005 o_SCmdAccept SHALL be high combinationally whenever i_MCmd is READ or WRITE; no wait states.
REQ-006 Response SHALL be registered: o_SResp DVA for exactly one cycle, one cycle after the accepted command; NULL otherwise.
REQ-007 Access to unmapped offset, write to ro register, or read of CONSOLE SHALL return ERR instead of DVA, with no state change.
REQ-008 o_SData SHALL hold read data in the DVA cycle and zero in all other cycles.
REQ-009 Writes to CTRL, WDOG, SCRATCH SHALL update only bytes with i_MByteEn set.
REQ-010 CTRL write with bit0=1 SHALL request finish; bit31 of the written value SHALL set error.
REQ-011 FSM states RUN, DRAIN, DONE: RUN->DRAIN on finish request or watchdog expiry; DRAIN->DONE after FINISH_DELAY cycles; DONE terminal until reset.
REQ-012 o_finish SHALL assert the cycle after entering DRAIN and stay high; o_error SHALL assert with it when cause is error.
REQ-013 In DRAIN/DONE, CTRL writes SHALL complete with DVA but not alter o_error or the FSM.
REQ-014 Entering DONE SHALL, in simulation only, print status and call $finish; synthesis ignores it.
REQ-015 STATUS read: bit0 finish, bit1 error, bit2 watchdog expired, bits[4:3] FSM state (RUN=0, DRAIN=1, DONE=2).
REQ-016 64-bit cycle counter SHALL increment every cycle from 0 after reset and wrap 2^64-1 -> 0.
REQ-017 Reading CYCLE_LO SHALL snapshot upper 32 bits; CYCLE_HI read returns snapshot, not live value.
REQ-018 WDOG nonzero SHALL decrement once per cycle in RUN; transition 1->0 SHALL set expired and error and enter DRAIN.
REQ-019 WDOG write in same cycle as 1->0 transition SHALL win: new value loaded, no expiry.
REQ-020 WDOG write of 0 SHALL disable; watchdog frozen outside RUN.
REQ-021 Watchdog expiry and CTRL finish write in same cycle SHALL yield error=1.
REQ-022 CONSOLE write with i_MByteEn[0]=1 SHALL pulse o_con_valid one cycle later with o_con_data=i_MData[7:0]; simulation SHALL $write the character.

Reset
REQ-023 On rst: FSM=RUN, o_finish=0, o_error=0, o_SResp=NULL, o_SData=0, o_con_valid=0, o_con_data=0, counter=0, snapshot=0, CTRL=0, SCRATCH=0, WDOG=WDOG_RESET, expired=0.
REQ-024 rst asserted in DRAIN SHALL abort termination; no $finish.

Verification
REQ-025 Write CTRL 0x000F_FFF0, read CTRL -> DVA, SData 0x000F_FFF0, o_finish=0.
REQ-026 Write CTRL 0x0000_0001 -> o_finish=1 next cycle, o_error=0, $finish after 16 cycles.
REQ-027 Write WDOG 5, idle -> expiry 5 cycles later, STATUS=0x0000_000F then DRAIN, o_error=1.
REQ-028 Write SCRATCH[1] 0xAABBCCDD, then byte-enable 0x2 write 0x0000_1100 -> read 0xAABB11DD.
REQ-029 Read offset 0x18 and write CYCLE_LO -> SResp ERR, registers unchanged.
REQ-030 Write CONSOLE 0x41 -> o_con_valid one cycle, o_con_data 0x41; rst during DRAIN -> o_finish=0, no termination.
